// File: rtl/ps2_mouse_bridge.sv
// ps2_mouse_bridge
// Receives PS/2 mouse packets, keeps X/Y/wheel accumulators plus the button
// state, and writes them out to three external port-register latches as a
// strobed sequence X, Y, KEY on a shared 8-bit data bus.
//
// Ports
//   i_clk       system clock, all logic on its rising edge
//   i_rst_n     synchronous active-low reset
//   i_ps2_clk   PS/2 device clock (asynchronous, input only)
//   i_ps2_data  PS/2 device data (asynchronous, input only)
//   o_di        data bus to the port-register latches
//   o_mx        X register write strobe (latches on rising edge)
//   o_my        Y register write strobe (latches on rising edge)
//   o_mkey      button/wheel register write strobe (latches on rising edge)
//   o_pkt_err   one-cycle pulse when a frame or packet is discarded
module ps2_mouse_bridge #(
    parameter int WHEEL_EN       = 1,
    parameter int TIMEOUT_CYCLES = 20000,
    parameter int STROBE_CYCLES  = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_di,
    output logic       o_mx,
    output logic       o_my,
    output logic       o_mkey,
    output logic       o_pkt_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam int STB_W = $clog2(STROBE_CYCLES + 2) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET_X = 3'd1,
        S_STB_X = 3'd2,
        S_SET_Y = 3'd3,
        S_STB_Y = 3'd4,
        S_SET_K = 3'd5,
        S_STB_K = 3'd6
    } state_t;

    // Odd parity: data plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

    // Synchronizers and falling-edge detector
    logic [1:0] r_clk_sync;
    logic [1:0] r_data_sync;
    logic       r_clk_prev;

    // Frame / packet state
    logic [9:0]      r_shift;
    logic [3:0]      r_bit_cnt;
    logic [1:0]      r_pkt_idx;
    logic [TO_W-1:0] r_to_cnt;
    logic [7:0]      r_b0;
    logic [7:0]      r_b1;
    logic [7:0]      r_b2;
    logic            r_pkt_err;

    // Accumulators
    logic [7:0] r_x;
    logic [7:0] r_y;
    logic [3:0] r_w;
    logic [2:0] r_btn;

    // Update sequencer
    state_t           r_state;
    logic             r_pending;
    logic [STB_W-1:0] r_stb_cnt;
    logic [7:0]       r_snap_y;
    logic [7:0]       r_snap_k;
    logic [7:0]       r_di;
    logic             r_mx;
    logic             r_my;
    logic             r_mkey;

    // Combinational decode
    logic        w_fall;
    logic        w_bit;
    logic [10:0] w_frame;
    logic [7:0]  w_frame_data;
    logic        w_frame_ok;
    logic        w_frame_end;
    logic        w_active;
    logic        w_timeout;
    logic        w_pkt_done;
    logic [7:0]  w_dy;
    logic [3:0]  w_dz;
    logic [7:0]  w_key;
    logic        w_take;

    assign w_fall = r_clk_prev & ~r_clk_sync[1];
    assign w_bit  = r_data_sync[1];

    // Two-flop synchronizers for both PS/2 lines plus the previous clock sample
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clk_sync  <= 2'b11;
            r_data_sync <= 2'b11;
            r_clk_prev  <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
            r_data_sync <= {r_data_sync[0], i_ps2_data};
            r_clk_prev  <= r_clk_sync[1];
        end
    end

    // Frame assembly, validity and inactivity-timeout decode
    always_comb begin
        // The 11th bit is taken live so the frame is judged on its last edge.
        w_frame      = {w_bit, r_shift};
        w_frame_data = w_frame[8:1];
        w_frame_ok   = (w_frame[0] == 1'b0) && (w_frame[10] == 1'b1)
                       && odd_parity_ok(w_frame[8:1], w_frame[9]);
        w_frame_end  = w_fall && (r_bit_cnt == 4'd10);
        w_active     = (r_bit_cnt != 4'd0) || (r_pkt_idx != 2'd0);
        w_timeout    = w_active && !w_fall && (r_to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
    end

    // Packet completion and the dY / Z terms that go with it
    always_comb begin
        w_pkt_done = 1'b0;
        w_dy       = w_frame_data;
        w_dz       = 4'h0;
        if (w_frame_end && w_frame_ok) begin
            if ((WHEEL_EN == 0) && (r_pkt_idx == 2'd2)) begin
                w_pkt_done = 1'b1;
                w_dy       = w_frame_data;
                w_dz       = 4'h0;
            end else if ((WHEEL_EN != 0) && (r_pkt_idx == 2'd3)) begin
                w_pkt_done = 1'b1;
                w_dy       = r_b2;
                w_dz       = w_frame_data[3:0];
            end else begin
                w_pkt_done = 1'b0;
            end
        end else begin
            w_pkt_done = 1'b0;
        end
    end

    // KEY byte: wheel nibble, a constant 1, then active-low buttons
    always_comb begin
        w_key  = {((WHEEL_EN != 0) ? r_w : 4'hF), 1'b1, ~r_btn[2], ~r_btn[1], ~r_btn[0]};
        w_take = (r_state == S_IDLE) && r_pending;
    end

    // Frame reception, packet collection, timeout abort and accumulation
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shift   <= 10'h000;
            r_bit_cnt <= 4'd0;
            r_pkt_idx <= 2'd0;
            r_to_cnt  <= '0;
            r_b0      <= 8'h00;
            r_b1      <= 8'h00;
            r_b2      <= 8'h00;
            r_pkt_err <= 1'b0;
            r_x       <= 8'h00;
            r_y       <= 8'h00;
            r_w       <= 4'hF;
            r_btn     <= 3'b000;
        end else begin
            r_pkt_err <= 1'b0;
            if (w_timeout) begin
                r_bit_cnt <= 4'd0;
                r_pkt_idx <= 2'd0;
                r_to_cnt  <= '0;
                r_pkt_err <= 1'b1;
            end else if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt <= 4'd0;
                    if (!w_frame_ok) begin
                        r_pkt_idx <= 2'd0;
                        r_pkt_err <= 1'b1;
                    end else begin
                        case (r_pkt_idx)
                            2'd0: begin
                                // Bit 3 is always set in a real byte 0; use it to resync.
                                if (w_frame_data[3]) begin
                                    r_b0      <= w_frame_data;
                                    r_pkt_idx <= 2'd1;
                                end else begin
                                    r_pkt_err <= 1'b1;
                                end
                            end
                            2'd1: begin
                                r_b1      <= w_frame_data;
                                r_pkt_idx <= 2'd2;
                            end
                            2'd2: begin
                                r_b2      <= w_frame_data;
                                r_pkt_idx <= (WHEEL_EN != 0) ? 2'd3 : 2'd0;
                            end
                            2'd3: begin
                                r_pkt_idx <= 2'd0;
                            end
                            default: begin
                                r_pkt_idx <= 2'd0;
                            end
                        endcase
                    end
                end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                    r_shift   <= {w_bit, r_shift[9:1]};
                end
            end else if (w_active) begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end else begin
                r_to_cnt <= '0;
            end

            if (w_pkt_done) begin
                // Overflowed deltas are meaningless, so they are dropped.
                if (!r_b0[6]) begin
                    r_x <= r_x + r_b1;
                end
                if (!r_b0[7]) begin
                    r_y <= r_y + w_dy;
                end
                if (WHEEL_EN != 0) begin
                    r_w <= r_w + w_dz;
                end
                r_btn <= r_b0[2:0];
            end
        end
    end

    // Update sequencer: SET puts data on the bus, STB pulses the strobe then holds DI one cycle
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= 1'b1;
            r_stb_cnt <= '0;
            r_snap_y  <= 8'h00;
            r_snap_k  <= 8'hFF;
            r_di      <= 8'hFF;
            r_mx      <= 1'b0;
            r_my      <= 1'b0;
            r_mkey    <= 1'b0;
        end else begin
            // A new packet always wins over the clear, so no update is lost.
            r_pending <= w_pkt_done | (r_pending & ~w_take);
            case (r_state)
                S_IDLE: begin
                    if (r_pending) begin
                        r_state  <= S_SET_X;
                        r_di     <= r_x;
                        r_snap_y <= r_y;
                        r_snap_k <= w_key;
                    end
                end
                S_SET_X: begin
                    r_state   <= S_STB_X;
                    r_mx      <= 1'b1;
                    r_stb_cnt <= '0;
                end
                S_STB_X: begin
                    r_stb_cnt <= r_stb_cnt + STB_W'(1);
                    if (r_stb_cnt == STB_W'(STROBE_CYCLES - 1)) begin
                        r_mx <= 1'b0;
                    end
                    if (r_stb_cnt == STB_W'(STROBE_CYCLES)) begin
                        r_state <= S_SET_Y;
                        r_di    <= r_snap_y;
                    end
                end
                S_SET_Y: begin
                    r_state   <= S_STB_Y;
                    r_my      <= 1'b1;
                    r_stb_cnt <= '0;
                end
                S_STB_Y: begin
                    r_stb_cnt <= r_stb_cnt + STB_W'(1);
                    if (r_stb_cnt == STB_W'(STROBE_CYCLES - 1)) begin
                        r_my <= 1'b0;
                    end
                    if (r_stb_cnt == STB_W'(STROBE_CYCLES)) begin
                        r_state <= S_SET_K;
                        r_di    <= r_snap_k;
                    end
                end
                S_SET_K: begin
                    r_state   <= S_STB_K;
                    r_mkey    <= 1'b1;
                    r_stb_cnt <= '0;
                end
                S_STB_K: begin
                    r_stb_cnt <= r_stb_cnt + STB_W'(1);
                    if (r_stb_cnt == STB_W'(STROBE_CYCLES - 1)) begin
                        r_mkey <= 1'b0;
                    end
                    if (r_stb_cnt == STB_W'(STROBE_CYCLES)) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_mx    <= 1'b0;
                    r_my    <= 1'b0;
                    r_mkey  <= 1'b0;
                end
            endcase
        end
    end

    assign o_di      = r_di;
    assign o_mx      = r_mx;
    assign o_my      = r_my;
    assign o_mkey    = r_mkey;
    assign o_pkt_err = r_pkt_err;

endmodule

// File: tb/tb_ps2_mouse_bridge.sv
// Testbench for ps2_mouse_bridge: drives PS/2 frames and scores every
// latch write against a queue of expected (strobe, data) pairs.
module tb_ps2_mouse_bridge;

    localparam int HALF = 4;
    localparam int TOUT = 200;
    localparam int STB  = 600;

    typedef struct packed {
        logic [2:0] stb;
        logic [7:0] val;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] di;
    logic       mx;
    logic       my;
    logic       mkey;
    logic       pkt_err;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    int strobe_count = 0;
    int mon_width = 0;
    logic [7:0] mon_cap = 8'h00;
    logic [2:0] prev_stb = 3'b000;
    logic [7:0] last_x = 8'h00;
    logic [7:0] last_y = 8'h00;
    logic [7:0] last_k = 8'h00;
    exp_t q[$];

    // Reference model of the accumulators
    logic [7:0] m_x;
    logic [7:0] m_y;
    logic [3:0] m_w;
    logic [2:0] m_btn;

    ps2_mouse_bridge #(
        .WHEEL_EN(1),
        .TIMEOUT_CYCLES(TOUT),
        .STROBE_CYCLES(STB)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_ps2_clk(ps2_clk),
        .i_ps2_data(ps2_data),
        .o_di(di),
        .o_mx(mx),
        .o_my(my),
        .o_mkey(mkey),
        .o_pkt_err(pkt_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = 8'h00;
        m_y = 8'h00;
        m_w = 4'hF;
        m_btn = 3'b000;
    endtask

    task automatic push_seq();
        q.push_back({3'b001, m_x});
        q.push_back({3'b010, m_y});
        q.push_back({3'b100, {m_w, 1'b1, ~m_btn}});
    endtask

    task automatic model_pkt(input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3);
        if (!b0[6]) m_x = m_x + b1;
        if (!b0[7]) m_y = m_y + b2;
        m_w = m_w + b3[3:0];
        m_btn = b0[2:0];
        push_seq();
    endtask

    task automatic ps2_frame(input logic [7:0] d, input logic bad_par);
        logic [10:0] f;
        f = {1'b1, (~^d) ^ bad_par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2_data = f[i];
            clks(HALF);
            ps2_clk = 1'b0;
            clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        clks(2 * HALF);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        ps2_frame(b0, 1'b0);
        ps2_frame(b1, 1'b0);
        ps2_frame(b2, 1'b0);
        ps2_frame(b3, 1'b0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((q.size() != 0 || {mkey, my, mx} != 3'b000) && n < 8000) begin
            clks(1);
            n++;
        end
        clks(20);
        chk(tag, q.size(), 0);
    endtask

    // Scoreboard monitor: pops one expectation per strobe rise, checks width and DI stability
    always @(negedge clk) begin : monitor
        logic [2:0] stb;
        exp_t e;
        stb = {mkey, my, mx};
        if (!rst_n) begin
            prev_stb = 3'b000;
            mon_width = 0;
        end else begin
            chk("one_strobe", ($countones(stb) <= 1), 1);
            if (pkt_err) err_pulses++;
            if (stb != 3'b000 && prev_stb == 3'b000) begin
                strobe_count++;
                chk("strobe_expected", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk("strobe_kind", stb, e.stb);
                    chk("strobe_data", di, e.val);
                end
                if (stb == 3'b001) last_x = di;
                if (stb == 3'b010) last_y = di;
                if (stb == 3'b100) last_k = di;
                mon_cap = di;
                mon_width = 1;
            end else if (stb != 3'b000) begin
                mon_width++;
                chk("di_stable", di, mon_cap);
            end else if (prev_stb != 3'b000) begin
                chk("strobe_width", mon_width, STB);
                chk("di_hold", di, mon_cap);
            end
            prev_stb = stb;
        end
    end

    initial begin
        int sc0;
        int n;
        rst_n = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        clks(5);
        chk("rst_di", di, 8'hFF);
        chk("rst_strobes", {mkey, my, mx}, 3'b000);
        chk("rst_err", pkt_err, 1'b0);

        // Reset release: first sequence writes 00, 00, FF
        push_seq();
        rst_n = 1'b1;
        wait_idle("idle_after_reset");
        chk("reset_seq_x", last_x, 8'h00);
        chk("reset_seq_y", last_y, 8'h00);
        chk("reset_seq_k", last_k, 8'hFF);
        chk("reset_seq_count", strobe_count, 3);

        // Basic wheel packet
        model_pkt(8'h08, 8'h05, 8'h03, 8'h01);
        send_pkt(8'h08, 8'h05, 8'h03, 8'h01);
        wait_idle("idle_p1");
        chk("p1_x", last_x, 8'h05);
        chk("p1_y", last_y, 8'h03);
        chk("p1_k", last_k, 8'h0F);

        // Bring X to 01, then negative dX with left button
        model_pkt(8'h18, 8'hFC, 8'h00, 8'h00);
        send_pkt(8'h18, 8'hFC, 8'h00, 8'h00);
        wait_idle("idle_p2");
        chk("p2_x", last_x, 8'h01);
        model_pkt(8'h19, 8'hFE, 8'h00, 8'h00);
        send_pkt(8'h19, 8'hFE, 8'h00, 8'h00);
        wait_idle("idle_p3");
        chk("p3_x", last_x, 8'hFF);
        chk("p3_k_left", last_k[0], 1'b0);

        // Both overflow flags: deltas ignored
        model_pkt(8'hC8, 8'h10, 8'h10, 8'h00);
        send_pkt(8'hC8, 8'h10, 8'h10, 8'h00);
        wait_idle("idle_p4");
        chk("ovf_x", last_x, 8'hFF);
        chk("ovf_y", last_y, 8'h03);
        chk("no_err_yet", err_pulses, 0);

        // Bad parity on byte 1
        sc0 = strobe_count;
        ps2_frame(8'h08, 1'b0);
        ps2_frame(8'h05, 1'b1);
        clks(100);
        chk("parity_err_pulse", err_pulses, 1);
        chk("parity_no_strobe", strobe_count, sc0);
        model_pkt(8'h09, 8'h01, 8'h02, 8'h0F);
        send_pkt(8'h09, 8'h01, 8'h02, 8'h0F);
        wait_idle("idle_p5");
        chk("p5_x", last_x, 8'h00);
        chk("p5_y", last_y, 8'h05);
        chk("p5_k", last_k, 8'hFE);

        // Resync: byte 0 without bit 3
        ps2_frame(8'h00, 1'b0);
        clks(20);
        chk("resync_err_pulse", err_pulses, 2);
        model_pkt(8'h28, 8'h00, 8'hFF, 8'h00);
        send_pkt(8'h28, 8'h00, 8'hFF, 8'h00);
        wait_idle("idle_p6");
        chk("p6_y", last_y, 8'h04);

        // Six edges then silence beyond the timeout
        sc0 = strobe_count;
        for (int i = 0; i < 6; i++) begin
            ps2_data = 1'b0;
            clks(HALF);
            ps2_clk = 1'b0;
            clks(HALF);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        clks(TOUT + 100);
        chk("timeout_err_pulse", err_pulses, 3);
        chk("timeout_no_strobe", strobe_count, sc0);
        model_pkt(8'h08, 8'h01, 8'h00, 8'h00);
        send_pkt(8'h08, 8'h01, 8'h00, 8'h00);
        wait_idle("idle_p7");
        chk("p7_x", last_x, 8'h01);

        // Second packet lands while the first sequence is strobing X
        sc0 = strobe_count;
        model_pkt(8'h0A, 8'h10, 8'h20, 8'h01);
        send_pkt(8'h0A, 8'h10, 8'h20, 8'h01);
        chk("overlap_in_stb_x", mx, 1'b1);
        model_pkt(8'h08, 8'h01, 8'h01, 8'h01);
        send_pkt(8'h08, 8'h01, 8'h01, 8'h01);
        wait_idle("idle_overlap");
        chk("overlap_strobes", strobe_count - sc0, 6);
        chk("overlap_x", last_x, 8'h12);
        chk("overlap_y", last_y, 8'h25);
        chk("overlap_k", last_k, 8'h1F);
        chk("err_total", err_pulses, 3);

        // Reset while the X strobe is high
        model_pkt(8'h08, 8'h01, 8'h00, 8'h00);
        send_pkt(8'h08, 8'h01, 8'h00, 8'h00);
        n = 0;
        while (mx !== 1'b1 && n < 2000) begin
            clks(1);
            n++;
        end
        chk("mx_rose_before_reset", mx, 1'b1);
        clks(2);
        rst_n = 1'b0;
        q.delete();
        model_reset();
        push_seq();
        clks(1);
        chk("rst_drops_strobe", {mkey, my, mx}, 3'b000);
        chk("rst_mid_di", di, 8'hFF);
        rst_n = 1'b1;
        wait_idle("idle_after_mid_reset");
        chk("mid_reset_x", last_x, 8'h00);
        chk("mid_reset_y", last_y, 8'h00);
        chk("mid_reset_k", last_k, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_bridge.md
PS2_MOUSE_BRIDGE -- requirements
Module: ps2_mouse_bridge

Interface
REQ-001 SHALL have parameter WHEEL_EN, default 1: 1 = 4-byte IntelliMouse packets, 0 = 3-byte packets with wheel output forced to 4'b1111.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 20000: CLK cycles of PS2_CLK inactivity that abort a partial frame or packet.
REQ-003 SHALL have parameter STROBE_CYCLES, default 4: CLK cycles for which each of MX/MY/MKEY is held high.
REQ-004 CLK  in  1  system clock; all logic on its rising edge.
REQ-005 RST_N  in  1  reset; one clock; reset is synchronous and active-low.
REQ-006 PS2_CLK  in  1  PS/2 device clock, asynchronous; the block never drives it.
REQ-007 PS2_DATA  in  1  PS/2 device data, asynchronous; the block never drives it.
REQ-008 DI  out  8  data bus to the port-register latches.
REQ-009 MX  out  1  X register write strobe; data is latched on the rising edge.
REQ-010 MY  out  1  Y register write strobe; data is latched on the rising edge.
REQ-011 MKEY  out  1  button/wheel register write strobe; data is latched on the rising edge.
REQ-012 PKT_ERR  out  1  one-cycle pulse when a frame or packet is discarded.

Function
REQ-013 SHALL pass PS2_CLK and PS2_DATA through 2-FF synchronizers and detect the PS2_CLK falling edge from the synchronized signal.
REQ-014 SHALL sample PS2_DATA on each detected falling edge and assemble an 11-bit frame: start=0, 8 data bits LSB first, odd parity, stop=1.
REQ-015 SHALL discard the frame, clear the packet index and pulse PKT_ERR on a start, parity or stop error.
REQ-016 SHALL accept a frame as packet byte 0 only when data bit 3 = 1; otherwise it discards the byte, pulses PKT_ERR and stays at index 0 (resync).
REQ-017 SHALL collect packet bytes: byte0 = {Yovf, Xovf, Ysign, Xsign, 1, M, R, L}, byte1 = dX[7:0], byte2 = dY[7:0], and byte3 = Z nibble [3:0] when WHEEL_EN = 1.
REQ-018 SHALL abort a partial frame and a partial packet after TIMEOUT_CYCLES CLK cycles without a PS2_CLK falling edge; the next falling edge then starts a new frame at packet index 0, and PKT_ERR is pulsed.
REQ-019 On packet completion, the X accumulator SHALL update X <= X + {Xsign, dX}[7:0] (8-bit wrap); the dX term is skipped when Xovf = 1.
REQ-020 On packet completion, the Y accumulator SHALL update Y <= Y + {Ysign, dY}[7:0] (8-bit wrap, up = increase); the dY term is skipped when Yovf = 1.
REQ-021 On packet completion with WHEEL_EN = 1, the wheel accumulator W SHALL update W <= W + Z[3:0] (4-bit signed, wrap).
REQ-022 The KEY byte SHALL be {W or 4'b1111 per WHEEL_EN, 1, ~M, ~R, ~L}, with 0 = pressed.
REQ-023 The update FSM SHALL have states IDLE, SET_X, STB_X, SET_Y, STB_Y, SET_K, STB_K, in that order.
REQ-024 In each SET_* state (1 cycle), DI SHALL be driven to the value to be written while the strobe stays low.
REQ-025 In each STB_* state, the strobe SHALL be high for STROBE_CYCLES cycles with DI stable; DI SHALL hold for 1 cycle after the strobe falls before the next SET_*.
REQ-026 Exactly one strobe SHALL be high at any time; DI SHALL change only in SET_* states.
REQ-027 A completed packet SHALL set a pending flag; IDLE with pending set SHALL clear the flag and enter SET_X.
REQ-028 The values written SHALL be snapshotted at SET_X; a packet completing mid-sequence only re-sets pending, giving one further sequence with the latest values (no loss, no queue).
REQ-029 Frame reception and accumulation SHALL continue independently of the update FSM.

Reset
REQ-030 While RST_N = 0 on a CLK edge: X = 8'h00, Y = 8'h00, W = 4'hF, buttons released, DI = 8'hFF, MX = MY = MKEY = 0, PKT_ERR = 0, FSM = IDLE, frame and packet state cleared, timeout counter cleared.
REQ-031 Reset SHALL set pending = 1, so the first sequence after reset writes X = 00, Y = 00, KEY = FF.
REQ-032 Reset asserted mid-strobe SHALL drop the strobe in the same cycle and abort the sequence.

Verification
REQ-033 Reset release, idle bus -> sequence MX(00), MY(00), MKEY(FF), each strobe STROBE_CYCLES high, then IDLE.
REQ-034 Packet 08,05,03,01 (WHEEL_EN = 1) -> writes X = 05, Y = 03, KEY = 0xF (W = F+1 = 0) -> KEY = 8'h0F.
REQ-035 Packet with byte0 = 19 (L pressed, Xsign set), dX = FE, from X = 01 -> X = FF, KEY bit0 = 0.
REQ-036 Byte with bad parity as byte1 -> PKT_ERR pulse, no strobe, next valid packet accepted normally.
REQ-037 Second packet completes during STB_X of the first -> current sequence unchanged; exactly one extra sequence carries the summed values.
REQ-038 Six PS2_CLK edges then silence beyond TIMEOUT_CYCLES -> PKT_ERR pulse, partial frame dropped, next full packet decoded from index 0.
